mlp_seq_sched: RTL and testbench

Sequential scheduler for the red-wine 11-4-bit-input, 2-hidden, 6-class MLP classifier. It replaces the fully parallel combinational datapath with one shared signed multiply-accumulate unit, time-multiplexed over every neuron. It runs a running-max argmax and wraps the whole computation in valid/ready handshakes. It sits between the sensor-sample capture logic and the class-result consumer.

---
 rtl/mlp_redwine_pkg.sv | 47 ++++
 rtl/mlp_mac_unit.sv | 44 ++++
 rtl/mlp_seq_sched.sv | 135 +++++++++++++
 tb/tb_mlp_seq_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mlp_redwine_pkg.sv
// Shared constants, weights and FSM state type
// for the red-wine MLP sequential scheduler.
package mlp_redwine_pkg;

  localparam int IN_W_D  = 4;
  localparam int N_IN_D  = 11;
  localparam int N_HID_D = 2;
  localparam int N_OUT_D = 6;
  localparam int ACC_W_D = 12;
  localparam int W_W_D   = 4;
  localparam int H_W_D   = 9;

  typedef enum logic [1:0] {
    IDLE,
    L0,
    L1,
    DONE
  } state_t;

  typedef logic signed [W_W_D-1:0]   wgt_t;
  typedef logic signed [ACC_W_D-1:0] acc_t;

  // Weights reach +4, so they need a 4-bit signed holder.
  localparam wgt_t W0 [N_HID_D][N_IN_D] = '{
    '{ 4'sd0,  4'sd2,  4'sd0, 4'sd0, 4'sd0, 4'sd0,
       4'sd0,  4'sd1,  4'sd0, -4'sd2, -4'sd2},
    '{ 4'sd1, -4'sd2, -4'sd1, 4'sd0, 4'sd0, 4'sd1,
      -4'sd4,  4'sd0,  4'sd1,  4'sd4,  4'sd4}
  };

  localparam acc_t B0 [N_HID_D] = '{12'sd0, -12'sd9};

  localparam wgt_t W1 [N_OUT_D][N_HID_D] = '{
    '{ 4'sd1,  4'sd0},
    '{ 4'sd0,  4'sd0},
    '{ 4'sd0, -4'sd1},
    '{-4'sd1,  4'sd0},
    '{ 4'sd0,  4'sd0},
    '{ 4'sd0,  4'sd0}
  };

  localparam acc_t B1 [N_OUT_D] = '{
    -12'sd10, 12'sd11, 12'sd39,
     12'sd29, 12'sd13, 12'sd2
  };

endpackage

// File: rtl/mlp_mac_unit.sv
// Shared signed MAC: bias load or accumulate,
// with ReLU of the value being written.
module mlp_mac_unit
  import mlp_redwine_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int W_W   = W_W_D,
  parameter int OP_W  = H_W_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [W_W-1:0]   wgt,
  input  logic        [OP_W-1:0]  opnd,
  input  logic signed [ACC_W-1:0] bias,
  output logic        [OP_W-1:0]  relu_nxt
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] o_x;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] sum;

  assign w_x  = {{(ACC_W-W_W){wgt[W_W-1]}}, wgt};
  assign o_x  = {{(ACC_W-OP_W){1'b0}}, opnd};
  assign prod = w_x * o_x;
  assign sum  = (load ? bias : acc) + prod;

  // ReLU on the incoming sum lets the caller
  // latch a neuron on its final term edge.
  assign relu_nxt = sum[ACC_W-1] ? '0
                                 : sum[OP_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/mlp_seq_sched.sv
// Sequential MLP scheduler: FSM, counters,
// hidden regs, running argmax, handshakes.
module mlp_seq_sched
  import mlp_redwine_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int N_IN  = N_IN_D,
  parameter int N_HID = N_HID_D,
  parameter int N_OUT = N_OUT_D,
  parameter int ACC_W = ACC_W_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W*N_IN-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_class,
  output logic                 busy
);

  state_t state_q;
  state_t state_d;

  logic [3:0]           t_q;
  logic [2:0]           n_q;
  logic [IN_W*N_IN-1:0] x_q;
  logic [H_W_D-1:0]     h_q [N_HID];
  logic [H_W_D-1:0]     max_q;
  logic [2:0]           cls_q;

  logic                 last_t;
  logic                 last_n;
  wgt_t                 wgt;
  logic [H_W_D-1:0]     opnd;
  logic [ACC_W-1:0]     bias;
  logic [H_W_D-1:0]     relu_nxt;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == L0) ||
                     (state_q == L1);
  assign out_class = cls_q;

  always_comb begin
    last_t = 1'b0;
    last_n = 1'b0;
    wgt    = '0;
    opnd   = '0;
    bias   = '0;
    if (state_q == L0) begin
      last_t = (t_q == 4'(N_IN-1));
      last_n = (n_q == 3'(N_HID-1));
      wgt    = W0[n_q[0]][t_q];
      opnd   = H_W_D'(x_q[{t_q, 2'b00} +: IN_W]);
      bias   = B0[n_q[0]];
    end else begin
      last_t = (t_q == 4'(N_HID-1));
      last_n = (n_q == 3'(N_OUT-1));
      wgt    = W1[n_q][t_q[0]];
      opnd   = h_q[t_q[0]];
      bias   = B1[n_q];
    end
  end

  mlp_mac_unit #(
    .ACC_W (ACC_W),
    .W_W   (W_W_D),
    .OP_W  (H_W_D)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .load     (t_q == 4'd0),
    .wgt      (wgt),
    .opnd     (opnd),
    .bias     (bias),
    .relu_nxt (relu_nxt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = L0;
      L0:   if (last_t && last_n) state_d = L1;
      L1:   if (last_t && last_n) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q   <= '0;
      n_q   <= '0;
      x_q   <= '0;
      h_q   <= '{default: '0};
      max_q <= '0;
      cls_q <= '0;
    end else begin
      if (in_ready && in_valid) begin
        x_q <= in_data;
        t_q <= '0;
        n_q <= '0;
      end
      if (busy) begin
        if (last_t) begin
          t_q <= '0;
          n_q <= last_n ? 3'd0 : n_q + 3'd1;
        end else begin
          t_q <= t_q + 4'd1;
        end
        if (state_q == L0 && last_t) begin
          h_q[n_q[0]] <= relu_nxt;
        end
        // Strict compare keeps the lowest index on ties.
        if (state_q == L1 && last_t &&
            (n_q == 3'd0 || relu_nxt > max_q)) begin
          max_q <= relu_nxt;
          cls_q <= n_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mlp_seq_sched.sv
// Scoreboard bench for mlp_seq_sched: driver queues
// expected class/accept cycle, monitor checks.
module tb_mlp_seq_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [43:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  out_class;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit seen   = 1'b0;

  logic [2:0] exp_cls [$];
  int         exp_acc [$];

  mlp_seq_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, req);
    end
  endtask

  // Monitor: compare on the first cycle of each result.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (exp_cls.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid: got class %0d, expected no output",
                   out_class);
        end else begin
          chk("class", int'(out_class),
              int'(exp_cls.pop_front()));
          chk("latency", cyc - exp_acc.pop_front(), 34);
        end
      end
      if (!out_valid) seen = 1'b0;
    end
  end

  task automatic send(input logic [43:0] x,
                      input logic [2:0] cls,
                      output int acc);
    int n;
    acc = -1;
    @(negedge clk);
    in_data  = x;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: in_ready=0, expected 1");
    end else begin
      acc = cyc + 1;
      exp_cls.push_back(cls);
      exp_acc.push_back(acc);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_cls.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: pending=%0d, expected 0",
               exp_cls.size());
    end
  endtask

  initial begin
    int a;
    int r;
    int n;

    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_class", int'(out_class), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, class worked out by hand.
    send(44'h0000000000, 3'd2, a); in_valid = 1'b0;
    drain();
    send(44'hFFFFFFFFFFF, 3'd3, a); in_valid = 1'b0;
    drain();
    send(44'h0040000000F, 3'd2, a); in_valid = 1'b0;
    drain();
    send(44'h00FF0F000FF, 3'd0, a); in_valid = 1'b0;
    drain();
    send(44'h0F0F0F000F0, 3'd3, a); in_valid = 1'b0;
    drain();

    // Back-pressure with in_valid high and new data
    // presented while the first sample computes.
    out_ready = 1'b0;
    send(44'hFFFFFFFFFFF, 3'd3, a);
    in_data = 44'h0040000000F;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_class", int'(out_class), 3);
      chk("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    r = cyc;
    send(44'h0040000000F, 3'd2, a); in_valid = 1'b0;
    chk("bp_next_accept", a - r, 2);
    drain();

    // Async reset partway through L0.
    send(44'h0000000000, 3'd2, a); in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    exp_cls.delete();
    exp_acc.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    send(44'h0000000000, 3'd2, a); in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
